hilo_seq: RTL and testbench

- Sequencer that owns the HI/LO register pair and drives the shared ALU for MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- The ALU has a single 32-bit result port, so the block reads 64-bit results as two 32-bit reads.
- It also starts the iterative divider and waits for it to finish.
- It sits between decode/execute and the ALU, and raises busy so the pipeline stalls MFHI/MFLO and further HI/LO operations.

---
 rtl/hilo_seq.sv | 254 +++++++++++++++++++++++++
 tb/tb_hilo_seq.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_seq.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_seq
//  Description : HI/LO register sequencer. Owns the HI/LO pair and steps the
//                shared 32-bit ALU through MULT/MULTU (two result reads), and
//                DIV/DIVU (divider start, wait, quotient read, remainder read).
//                MTHI/MTLO write HI/LO directly. busy stalls the pipeline
//                while a multi-cycle operation is in flight.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk       in   1   clock, all state updates on the rising edge
//    rst_n     in   1   synchronous reset, active-low
//    op_valid  in   1   request valid
//    op        in   3   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO,
//                       6/7 reserved (no-op)
//    op_a      in  32   rs operand
//    op_b      in  32   rt operand
//    op_ready  out  1   high only when idle
//    busy      out  1   inverse of op_ready
//    done      out  1   one-cycle completion pulse
//    err       out  1   one-cycle pulse on divide-by-zero or divider timeout
//    hi, lo    out 32   HI / LO registers
//    alu_a     out 32   latched op_a
//    alu_b     out 32   latched op_b
//    alu_ctrl  out  4   ALU operation select
//    alu_out   in  32   ALU result
//    div_rst   out  1   divider start/reset, active-high
//    div_done  in   1   divider finished
// ============================================================================
module hilo_seq #(
    parameter int DIV_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        op_ready,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_ctrl,
    input  logic [31:0] alu_out,
    output logic        div_rst,
    input  logic        div_done
);

    // Counter is wide enough to hold DIV_TIMEOUT itself.
    localparam int          c_CNT_W   = $clog2(DIV_TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(DIV_TIMEOUT);

    localparam logic [2:0] c_OP_MULT  = 3'd0;
    localparam logic [2:0] c_OP_MULTU = 3'd1;
    localparam logic [2:0] c_OP_DIV   = 3'd2;
    localparam logic [2:0] c_OP_DIVU  = 3'd3;
    localparam logic [2:0] c_OP_MTHI  = 3'd4;
    localparam logic [2:0] c_OP_MTLO  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_MUL_HI    = 3'd1,
        S_MUL_LO    = 3'd2,
        S_DIV_START = 3'd3,
        S_DIV_WAIT  = 3'd4,
        S_DIV_Q     = 3'd5,
        S_DIV_R     = 3'd6
    } state_t;

    state_t              r_state;
    logic [31:0]         r_hi;
    logic [31:0]         r_lo;
    logic [31:0]         r_a;
    logic [31:0]         r_b;
    logic                r_uns;       // unsigned variant (MULTU/DIVU)
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_done;
    logic                r_err;
    logic                r_post_rst;  // first cycle after a reset edge

    state_t              w_state_nxt;
    logic [31:0]         w_hi_nxt;
    logic [31:0]         w_lo_nxt;
    logic [31:0]         w_a_nxt;
    logic [31:0]         w_b_nxt;
    logic                w_uns_nxt;
    logic [c_CNT_W-1:0]  w_cnt_nxt;
    logic [c_CNT_W-1:0]  w_cnt_inc;
    logic                w_done_nxt;
    logic                w_err_nxt;
    logic                w_ready;
    logic                w_div_rst;
    logic [3:0]          w_alu_ctrl;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_hi       <= 32'd0;
            r_lo       <= 32'd0;
            r_a        <= 32'd0;
            r_b        <= 32'd0;
            r_uns      <= 1'b0;
            r_cnt      <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_post_rst <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_hi       <= w_hi_nxt;
            r_lo       <= w_lo_nxt;
            r_a        <= w_a_nxt;
            r_b        <= w_b_nxt;
            r_uns      <= w_uns_nxt;
            r_cnt      <= w_cnt_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            r_post_rst <= 1'b0;
        end
    end

    assign w_cnt_inc = r_cnt + 1'b1;

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_uns_nxt   = r_uns;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_ready     = 1'b0;
        w_div_rst   = r_post_rst;
        w_alu_ctrl  = 4'b0000;

        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (op_valid) begin
                    // Operands and signedness are frozen for the whole op.
                    w_a_nxt   = op_a;
                    w_b_nxt   = op_b;
                    w_uns_nxt = op[0];
                    case (op)
                        c_OP_MTHI: begin
                            w_hi_nxt   = op_a;
                            w_done_nxt = 1'b1;
                        end
                        c_OP_MTLO: begin
                            w_lo_nxt   = op_a;
                            w_done_nxt = 1'b1;
                        end
                        c_OP_MULT, c_OP_MULTU: begin
                            w_state_nxt = S_MUL_HI;
                        end
                        c_OP_DIV, c_OP_DIVU: begin
                            // Divide-by-zero is rejected without touching
                            // the ALU or the divider.
                            if (op_b == 32'd0) begin
                                w_err_nxt  = 1'b1;
                                w_done_nxt = 1'b1;
                            end else begin
                                w_state_nxt = S_DIV_START;
                            end
                        end
                        default: begin
                            // Reserved codes complete as no-ops.
                            w_done_nxt = 1'b1;
                        end
                    endcase
                end
            end

            S_MUL_HI: begin
                w_alu_ctrl  = {2'b10, r_uns, 1'b1};
                w_hi_nxt    = alu_out;
                w_state_nxt = S_MUL_LO;
            end

            S_MUL_LO: begin
                w_alu_ctrl  = {2'b10, r_uns, 1'b0};
                w_lo_nxt    = alu_out;
                w_done_nxt  = 1'b1;
                w_state_nxt = S_IDLE;
            end

            S_DIV_START: begin
                // The quotient select also tells the divider which
                // signedness to use, so it is driven from here on.
                w_alu_ctrl  = {2'b11, r_uns, 1'b0};
                w_div_rst   = 1'b1;
                w_cnt_nxt   = '0;
                w_state_nxt = S_DIV_WAIT;
            end

            S_DIV_WAIT: begin
                w_alu_ctrl = {2'b11, r_uns, 1'b0};
                // div_done wins over a timeout reached in the same cycle.
                if (div_done) begin
                    w_state_nxt = S_DIV_Q;
                end else if (w_cnt_inc == c_TIMEOUT) begin
                    w_cnt_nxt   = w_cnt_inc;
                    w_err_nxt   = 1'b1;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end

            S_DIV_Q: begin
                w_alu_ctrl  = {2'b11, r_uns, 1'b0};
                w_lo_nxt    = alu_out;
                w_state_nxt = S_DIV_R;
            end

            S_DIV_R: begin
                w_alu_ctrl  = {2'b11, r_uns, 1'b1};
                w_hi_nxt    = alu_out;
                w_done_nxt  = 1'b1;
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign op_ready = w_ready;
    assign busy     = ~w_ready;
    assign done     = r_done;
    assign err      = r_err;
    assign hi       = r_hi;
    assign lo       = r_lo;
    assign alu_a    = r_a;
    assign alu_b    = r_b;
    assign alu_ctrl = w_alu_ctrl;
    assign div_rst  = w_div_rst;

endmodule
`default_nettype wire

// File: tb/tb_hilo_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hilo_seq
//  Description : Self-checking bench for hilo_seq. Provides an ALU and a
//                divider with programmable latency, drives directed and
//                random requests, and compares the DUT against a
//                transaction-level model every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hilo_seq;

    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] op_a, op_b;
    logic        op_ready, busy, done, err;
    logic [31:0] hi, lo, alu_a, alu_b, alu_out;
    logic [3:0]  alu_ctrl;
    logic        div_rst, div_done;

    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    hilo_seq #(.DIV_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op(op),
        .op_a(op_a), .op_b(op_b), .op_ready(op_ready), .busy(busy),
        .done(done), .err(err), .hi(hi), .lo(lo), .alu_a(alu_a),
        .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_out(alu_out),
        .div_rst(div_rst), .div_done(div_done)
    );

    // ---------------- arithmetic reference ----------------
    function automatic logic [63:0] f_mul(input logic uns, input logic [31:0] a, input logic [31:0] b);
        longint p;
        if (uns) return {32'd0, a} * {32'd0, b};
        p = longint'($signed(a)) * longint'($signed(b));
        return 64'(p);
    endfunction

    // returns {remainder, quotient}
    function automatic logic [63:0] f_div(input logic uns, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r;
        int sa, sb;
        if (b == 32'd0) return 64'd0;
        if (uns) begin
            q = a / b; r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a; r = 32'd0;
        end else begin
            sa = $signed(a); sb = $signed(b);
            q = 32'(sa / sb); r = 32'(sa % sb);
        end
        return {r, q};
    endfunction

    // ---------------- ALU and divider environment ----------------
    logic [63:0] e_ms, e_mu, e_ds, e_du;
    assign e_ms = f_mul(1'b0, alu_a, alu_b);
    assign e_mu = f_mul(1'b1, alu_a, alu_b);
    assign e_ds = f_div(1'b0, alu_a, alu_b);
    assign e_du = f_div(1'b1, alu_a, alu_b);

    always_comb begin
        alu_out = 32'hDEAD_BEEF;
        case (alu_ctrl)
            4'b1001: alu_out = e_ms[63:32];
            4'b1000: alu_out = e_ms[31:0];
            4'b1011: alu_out = e_mu[63:32];
            4'b1010: alu_out = e_mu[31:0];
            4'b1100: alu_out = e_ds[31:0];
            4'b1101: alu_out = e_ds[63:32];
            4'b1110: alu_out = e_du[31:0];
            4'b1111: alu_out = e_du[63:32];
            default: alu_out = 32'hDEAD_BEEF;
        endcase
    end

    // Divider: div_done pulses in the cfg_d-th cycle after div_rst drops.
    int cfg_d = 5;
    int dcnt  = 0;
    always @(posedge clk) begin
        if (div_rst) dcnt <= 0;
        else         dcnt <= dcnt + 1;
    end
    assign div_done = (dcnt == cfg_d - 1);

    // ---------------- transaction-level model ----------------
    // m_k counts edges since the accept edge of the op in flight.
    logic        m_busy, m_done, m_err, m_postrst;
    int          m_k, m_d;
    logic [2:0]  m_op;
    logic [31:0] m_a, m_b, m_hi, m_lo;
    logic [63:0] m_res;

    always @(posedge clk) begin
        m_done    <= 1'b0;
        m_err     <= 1'b0;
        m_postrst <= 1'b0;
        if (!rst_n) begin
            m_busy <= 1'b0; m_k <= 0; m_op <= 3'd0; m_d <= 0;
            m_a <= 0; m_b <= 0; m_hi <= 0; m_lo <= 0; m_res <= 0;
            m_postrst <= 1'b1;
        end else if (!m_busy) begin
            if (op_valid) begin
                m_a <= op_a; m_b <= op_b; m_op <= op; m_k <= 0; m_d <= cfg_d;
                case (op)
                    3'd0, 3'd1: begin
                        m_busy <= 1'b1;
                        m_res  <= f_mul(op[0], op_a, op_b);
                    end
                    3'd2, 3'd3: begin
                        if (op_b == 32'd0) begin
                            m_err <= 1'b1; m_done <= 1'b1;
                        end else begin
                            m_busy <= 1'b1;
                            m_res  <= f_div(op[0], op_a, op_b);
                        end
                    end
                    3'd4: begin m_hi <= op_a; m_done <= 1'b1; end
                    3'd5: begin m_lo <= op_a; m_done <= 1'b1; end
                    default: m_done <= 1'b1;
                endcase
            end
        end else begin
            m_k <= m_k + 1;
            if (!m_op[1]) begin
                if (m_k + 1 == 1) m_hi <= m_res[63:32];
                if (m_k + 1 == 2) begin
                    m_lo <= m_res[31:0]; m_busy <= 1'b0; m_done <= 1'b1;
                end
            end else if (m_d <= TO) begin
                if (m_k + 1 == m_d + 2) m_lo <= m_res[31:0];
                if (m_k + 1 == m_d + 3) begin
                    m_hi <= m_res[63:32]; m_busy <= 1'b0; m_done <= 1'b1;
                end
            end else if (m_k + 1 == TO + 1) begin
                m_busy <= 1'b0; m_err <= 1'b1; m_done <= 1'b1;
            end
        end
    end

    logic [3:0] x_ctrl;
    logic       x_divrst;
    always_comb begin
        x_ctrl   = 4'b0000;
        x_divrst = m_postrst;
        if (m_busy) begin
            if (!m_op[1]) begin
                x_ctrl = (m_k == 0) ? {2'b10, m_op[0], 1'b1} : {2'b10, m_op[0], 1'b0};
            end else begin
                x_ctrl = (m_d <= TO && m_k == m_d + 2) ? {2'b11, m_op[0], 1'b1}
                                                      : {2'b11, m_op[0], 1'b0};
                if (m_k == 0) x_divrst = 1'b1;
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("op_ready", 32'(op_ready), 32'(!m_busy));
            check("busy",     32'(busy),     32'(m_busy));
            check("done",     32'(done),     32'(m_done));
            check("err",      32'(err),      32'(m_err));
            check("hi",       hi,            m_hi);
            check("lo",       lo,            m_lo);
            check("alu_a",    alu_a,         m_a);
            check("alu_b",    alu_b,         m_b);
            check("alu_ctrl", 32'(alu_ctrl), 32'(x_ctrl));
            check("div_rst",  32'(div_rst),  32'(x_divrst));
        end
    end

    // ---------------- driver ----------------
    task automatic wait_ready(output int n);
        n = 0;
        while (!op_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) check("ready_timeout", 32'(op_ready), 32'd1);
    endtask

    // Called at a negedge; returns at the negedge right after the accept edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int d);
        int n;
        if (o == 3'd2 || o == 3'd3) begin
            wait_ready(n);
            cfg_d = d;
        end
        op_valid = 1'b1; op = o; op_a = a; op_b = b;
        wait_ready(n);
        @(negedge clk);
        op_valid = 1'b0; op = 3'($urandom); op_a = $urandom; op_b = $urandom;
    endtask

    task automatic pulse_reset();
        op_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n    = 1'b1;
    endtask

    initial begin
        int n;
        rst_n = 1'b0; op_valid = 1'b0; op = 3'd0; op_a = 0; op_b = 0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_divrst", 32'(div_rst), 32'd1);
        check("rst_ctrl", 32'(alu_ctrl), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // MULT -2 * 3
        issue(3'd0, 32'hFFFF_FFFE, 32'd3, 1);
        wait_ready(n);
        check("mult_lat", 32'(n), 32'd2);
        check("mult_done", 32'(done), 32'd1);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFA);

        // MULTU max * max
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        wait_ready(n);
        check("multu_hi", hi, 32'hFFFF_FFFE);
        check("multu_lo", lo, 32'h0000_0001);

        // DIV -7 / 2 with 33 wait cycles
        issue(3'd2, 32'hFFFF_FFF9, 32'd2, 33);
        wait_ready(n);
        check("div_lat", 32'(n), 32'd36);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);

        // MTHI / MTLO then DIVU by zero
        issue(3'd4, 32'h1234, 32'd0, 1);
        issue(3'd5, 32'h5678, 32'd0, 1);
        issue(3'd3, 32'd99, 32'd0, 1);
        check("dz_err", 32'(err), 32'd1);
        check("dz_done", 32'(done), 32'd1);
        check("dz_ready", 32'(op_ready), 32'd1);
        check("dz_hi", hi, 32'h1234);
        check("dz_lo", lo, 32'h5678);

        // DIVU timeout, MTLO held while busy
        issue(3'd3, 32'd50, 32'd3, 1000);
        issue(3'd5, 32'hABCD, 32'd0, 1);
        check("to_hi", hi, 32'h1234);
        check("to_lo", lo, 32'hABCD);

        // div_done in the same cycle the counter reaches the limit
        issue(3'd2, 32'd100, 32'd7, TO);
        wait_ready(n);
        check("edge_lat", 32'(n), 32'(TO + 3));
        check("edge_lo", lo, 32'd14);
        check("edge_hi", hi, 32'd2);

        // reset while in MUL_LO
        issue(3'd0, 32'hFFFF_FFF9, 32'd8, 1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mrst_hi", hi, 32'd0);
        check("mrst_lo", lo, 32'd0);
        check("mrst_done", 32'(done), 32'd0);
        check("mrst_divrst", 32'(div_rst), 32'd1);
        check("mrst_ready", 32'(op_ready), 32'd1);
        rst_n = 1'b1;
        issue(3'd0, 32'd5, 32'd6, 1);
        wait_ready(n);
        check("post_lo", lo, 32'd30);
        check("post_hi", hi, 32'd0);

        // random traffic
        for (int i = 0; i < 300; i++) begin
            int r, d;
            logic [2:0] o;
            logic [31:0] a, b;
            r = $urandom_range(0, 99);
            if (r < 3) begin
                pulse_reset();
            end else begin
                o = 3'($urandom_range(0, 7));
                a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 1000)) : $urandom;
                b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
                d = ($urandom_range(0, 9) == 0) ? $urandom_range(60, 70) : $urandom_range(1, 12);
                issue(o, a, b, d);
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end
        wait_ready(n);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
